line_cache_sched: RTL and testbench
===================================

# line_cache_sched

Controller for the three-line rolling pixel cache that feeds the 3x3 neighbourhood (prev/cur/next line × prev/cur/next pixel) to the smoothing and grid datapath in the HDMI image generator. It owns three physical 240-pixel line banks and rotates their roles on each `nextLine`/`cacheUpdate` event. It refills the freed bank from the captured-frame line buffer through a grant-gated read port, and aliases the bank selects at the top and bottom edges so edge lines are replicated.

## Interface
- `LINE_PIXELS`, 240: pixels per GBA line.
- `LINES`, 160: lines per GBA frame.

- `pxlClk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `newFrameIn`  in  1  level from capture side; its rising edge starts a new frame.
- `nextLine`  in  1  one-cycle qualifier: advance to the next GBA line.
- `cacheUpdate`  in  1  one-cycle end-of-output-line strobe.
- `srcGrant`  in  1  source read port available this cycle.
- `srcRdEn`  out  1  read strobe to the line buffer.
- `srcRdLine`  out  8  source line address.
- `srcRdPxl`  out  8  source pixel address.
- `srcRdData`  in  24  RGB888 read data, valid 1 cycle after `srcRdEn`.
- `bankWrEn`  out  3  one-hot bank write enable.
- `bankWrAddr`  out  8  bank pixel address.
- `bankWrData`  out  24  equals `srcRdData`, combinational pass-through.
- `prevSel`, `curSel`, `nextSel`  out  2 each  physical bank index (0..2) per role.
- `lineIdx`  out  8  GBA line currently presented as cur.
- `busy`  out  1  high whenever state ≠ IDLE.
- `overrun`  out  1  sticky error; cleared only by `rst` or a new frame.

## Operation
- Registers: role pointers `p0` (line lineIdx−1), `p1` (lineIdx), `p2` (lineIdx+1); `lineIdx`; fill pixel counter `pc` (0..LINE_PIXELS); fill target bank; fill source line; `pending` (1 bit); `newFrameIn` delay flop.
- Selects: `curSel = p1`; `prevSel = (lineIdx==0) ? p1 : p0`; `nextSel = (lineIdx==LINES-1) ? p1 : p2`.
- Rotate request: `nextLine && cacheUpdate`. A request with `lineIdx==LINES-1` is ignored, with no error.
- States:
  - IDLE: on a rotate request, or on `pending`, rotate: `p0<=p1`, `p1<=p2`, `p2<=p0`, `lineIdx<=lineIdx+1`, clear `pending`. If the new `lineIdx+1 ≤ LINES-1`, go to FILL with target = old `p0` and source line = new `lineIdx+1`; otherwise stay in IDLE.
  - FILL: stream one line into the target bank; return to IDLE.
  - PRIME0: fill `p1` with line 0, then go to PRIME1.
  - PRIME1: fill `p2` with line 1, then go to IDLE.
- Rotate request during FILL: if `pending==0`, set `pending` and `overrun`. If `pending==1`, drop the request and set `overrun`.
- Rotate request during PRIME0/PRIME1: drop it and set `overrun`.
- Fill engine: `srcRdEn = fillState && srcGrant && pc < LINE_PIXELS`, with `srcRdPxl = pc`; `pc` increments only on `srcRdEn`. With `srcGrant` low the engine stalls and `pc` holds.
- Bank write path: `bankWrEn` is the 1-cycle delay of `srcRdEn` decoded one-hot to the target; `bankWrAddr` is the delayed `pc`.
- Fill completion: the state exits on the cycle the write of pixel LINE_PIXELS−1 occurs, and `pc` resets to 0.
- New frame (`newFrameIn` && !delayed): takes priority over everything in the same cycle. It aborts any fill and kills the in-flight write (`bankWrEn` = 0 next cycle), clears `pending`, `overrun` and `pc`, sets `lineIdx=0`, `p0=0`, `p1=1`, `p2=2`, and enters PRIME0.
- Width rules: `lineIdx` and `srcRdLine` are 8-bit unsigned. `lineIdx+1` is compared unsigned against `LINES-1`; no wrap.

## Timing
- Reset values: state IDLE; `lineIdx=0`; `p0=0`, `p1=1`, `p2=2`, so `prevSel=1`, `curSel=1`, `nextSel=2`.
- Also at reset: `srcRdEn=0`, `srcRdLine=0`, `srcRdPxl=0`, `bankWrEn=000`, `bankWrAddr=0`, `busy=0`, `overrun=0`, `pending=0`.
- Rotation timing: selects and `lineIdx` change the cycle after the accepted request. The first `srcRdEn` can occur that same cycle.
- Fill duration with continuous grant: LINE_PIXELS+1 cycles from entering FILL to `busy` low (241 for the default).
- Priming duration with continuous grant: 2×241 cycles after the new-frame edge.
- `pending` rotation: executes the cycle after FILL returns to IDLE.

## Test plan
- Reset, then a `newFrameIn` rise with `srcGrant=1` → reads line 0 pixels 0..239, then line 1. `bankWrEn=010` for 240 cycles, then `100`. `busy` falls 482 cycles after the edge. Selects are 1/1/2.
- In IDLE with `lineIdx=0`, pulse a rotate → `lineIdx=1`, `prevSel=1`, `curSel=2`, `nextSel=0`. Bank 0 fills from line 2 over 241 cycles.
- Toggle `srcGrant` 1/0 every cycle during a fill → `srcRdPxl` advances only on granted cycles, all 240 writes land at addresses 0..239, and the fill takes 480 cycles.
- Rotate mid-FILL, then a second rotate → `overrun=1`. Exactly one extra rotation executes after the fill; the second request is dropped.
- Advance to `lineIdx=159` → `nextSel==curSel`, no fill is started, and a further rotate changes nothing and leaves `overrun=0`.
- `newFrameIn` rise at pixel 100 of a fill → no `bankWrEn` on the next cycle, `overrun` clears, PRIME0 restarts at line 0 pixel 0.

Source files
------------

// File: rtl/line_cache_sched_if.sv
// Source line-buffer read port and line-bank write port of the rolling line cache.
// master: the scheduler; slave: the line buffer / bank memory side.
interface line_cache_sched_if;
   logic        srcGrant;
   logic        srcRdEn;
   logic [7:0]  srcRdLine;
   logic [7:0]  srcRdPxl;
   logic [23:0] srcRdData;
   logic [2:0]  bankWrEn;
   logic [7:0]  bankWrAddr;
   logic [23:0] bankWrData;

   modport master (
      input  srcGrant, srcRdData,
      output srcRdEn, srcRdLine, srcRdPxl, bankWrEn, bankWrAddr, bankWrData
   );

   modport slave (
      output srcGrant, srcRdData,
      input  srcRdEn, srcRdLine, srcRdPxl, bankWrEn, bankWrAddr, bankWrData
   );
endinterface

// File: rtl/line_cache_sched.sv
// Three-bank rolling line cache controller: rotates prev/cur/next bank roles per output
// line, refills the freed bank from the capture line buffer, and replicates edge lines.
module line_cache_sched #(
   parameter int LINE_PIXELS = 240,
   parameter int LINES       = 160
) (
   input  logic                   pxlClk,
   input  logic                   rst,
   input  logic                   newFrameIn,
   input  logic                   nextLine,
   input  logic                   cacheUpdate,
   line_cache_sched_if.master     bus,
   output logic [1:0]             prevSel,
   output logic [1:0]             curSel,
   output logic [1:0]             nextSel,
   output logic [7:0]             lineIdx,
   output logic                   busy,
   output logic                   overrun
);
   localparam logic [7:0] LAST_LINE = 8'(LINES - 1);
   localparam logic [7:0] NUM_PXL   = 8'(LINE_PIXELS);
   localparam logic [7:0] LAST_PXL  = 8'(LINE_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, FILL, PRIME0, PRIME1} state_t;

   state_t      state_reg;
   logic [1:0]  p0_reg, p1_reg, p2_reg;
   logic [1:0]  fill_bank_reg;
   logic [7:0]  line_reg;
   logic [7:0]  pc_reg;
   logic [7:0]  src_line_reg;
   logic [7:0]  wr_addr_reg;
   logic [2:0]  wr_en_reg;
   logic        pending_reg;
   logic        overrun_reg;
   logic        nf_dly_reg;

   logic        new_frame;
   logic        rotate_req;
   logic        rotate_go;
   logic        rd_en;
   logic        fill_done;
   logic [2:0]  bank_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_onehot
         assign bank_onehot[gi] = (fill_bank_reg == 2'(gi));
      end
   endgenerate

   assign new_frame  = newFrameIn && !nf_dly_reg;
   assign rotate_req = nextLine && cacheUpdate && (line_reg != LAST_LINE);
   assign rotate_go  = (rotate_req || pending_reg) && (line_reg != LAST_LINE);
   assign rd_en      = (state_reg != IDLE) && bus.srcGrant && (pc_reg < NUM_PXL);
   // A fill ends on the cycle its last pixel is written into the bank.
   assign fill_done  = (wr_en_reg != 3'b000) && (wr_addr_reg == LAST_PXL);

   always_ff @(posedge pxlClk) begin
      if (rst) begin
         state_reg     <= IDLE;
         p0_reg        <= 2'd0;
         p1_reg        <= 2'd1;
         p2_reg        <= 2'd2;
         fill_bank_reg <= 2'd0;
         line_reg      <= 8'd0;
         pc_reg        <= 8'd0;
         src_line_reg  <= 8'd0;
         wr_addr_reg   <= 8'd0;
         wr_en_reg     <= 3'b000;
         pending_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         nf_dly_reg    <= 1'b0;
      end else begin
         nf_dly_reg  <= newFrameIn;
         wr_en_reg   <= rd_en ? bank_onehot : 3'b000;
         wr_addr_reg <= pc_reg;
         if (rd_en) begin
            pc_reg <= pc_reg + 8'd1;
         end

         if (new_frame) begin
            // Abort everything, including the write launched by this cycle's read.
            state_reg     <= PRIME0;
            p0_reg        <= 2'd0;
            p1_reg        <= 2'd1;
            p2_reg        <= 2'd2;
            fill_bank_reg <= 2'd1;
            src_line_reg  <= 8'd0;
            line_reg      <= 8'd0;
            pc_reg        <= 8'd0;
            wr_en_reg     <= 3'b000;
            pending_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (rotate_go) begin
                     p0_reg      <= p1_reg;
                     p1_reg      <= p2_reg;
                     p2_reg      <= p0_reg;
                     line_reg    <= line_reg + 8'd1;
                     pending_reg <= 1'b0;
                     if ((line_reg + 8'd2) <= LAST_LINE) begin
                        state_reg     <= FILL;
                        fill_bank_reg <= p0_reg;
                        src_line_reg  <= line_reg + 8'd2;
                     end
                  end
               end
               FILL: begin
                  // One rotation may queue behind a fill; any further one is lost.
                  if (rotate_req) begin
                     overrun_reg <= 1'b1;
                     pending_reg <= 1'b1;
                  end
                  if (fill_done) begin
                     state_reg <= IDLE;
                     pc_reg    <= 8'd0;
                  end
               end
               PRIME0: begin
                  if (rotate_req) begin
                     overrun_reg <= 1'b1;
                  end
                  if (fill_done) begin
                     state_reg     <= PRIME1;
                     pc_reg        <= 8'd0;
                     fill_bank_reg <= p2_reg;
                     src_line_reg  <= 8'd1;
                  end
               end
               default: begin
                  if (rotate_req) begin
                     overrun_reg <= 1'b1;
                  end
                  if (fill_done) begin
                     state_reg <= IDLE;
                     pc_reg    <= 8'd0;
                  end
               end
            endcase
         end
      end
   end

   assign bus.srcRdEn    = rd_en;
   assign bus.srcRdLine  = src_line_reg;
   assign bus.srcRdPxl   = pc_reg;
   assign bus.bankWrEn   = wr_en_reg;
   assign bus.bankWrAddr = wr_addr_reg;
   assign bus.bankWrData = bus.srcRdData;

   // Edge lines alias onto cur so the 3x3 window replicates them.
   assign curSel  = p1_reg;
   assign prevSel = (line_reg == 8'd0) ? p1_reg : p0_reg;
   assign nextSel = (line_reg == LAST_LINE) ? p1_reg : p2_reg;
   assign lineIdx = line_reg;
   assign busy    = (state_reg != IDLE);
   assign overrun = overrun_reg;
endmodule

// File: tb/tb_line_cache_sched.sv
// Scoreboard bench for line_cache_sched: expected bank writes are queued by the stimulus
// and popped by a write monitor; control outputs are checked directly.
module tb_line_cache_sched;
   logic       pxlClk = 1'b0;
   logic       rst = 1'b1;
   logic       newFrameIn = 1'b0;
   logic       nextLine = 1'b0;
   logic       cacheUpdate = 1'b0;
   logic [1:0] prevSel, curSel, nextSel;
   logic [7:0] lineIdx;
   logic       busy, overrun;

   line_cache_sched_if bus();

   line_cache_sched dut (
      .pxlClk      (pxlClk),
      .rst         (rst),
      .newFrameIn  (newFrameIn),
      .nextLine    (nextLine),
      .cacheUpdate (cacheUpdate),
      .bus         (bus),
      .prevSel     (prevSel),
      .curSel      (curSel),
      .nextSel     (nextSel),
      .lineIdx     (lineIdx),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 pxlClk = ~pxlClk;

   typedef struct packed {
      logic [2:0]  en;
      logic [7:0]  addr;
      logic [23:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   bit  mon_on = 1'b0;

   function automatic logic [23:0] pix(input logic [7:0] line, input logic [7:0] px);
      return {line, px, line ^ px ^ 8'h5A};
   endfunction

   // Captured-frame line buffer: registered read, one cycle of latency.
   always @(posedge pxlClk) begin
      if (rst) bus.srcRdData <= 24'd0;
      else if (bus.srcRdEn) bus.srcRdData <= pix(bus.srcRdLine, bus.srcRdPxl);
   end

   always @(negedge pxlClk) begin : monitor
      wr_t got;
      wr_t want;
      if (mon_on && bus.bankWrEn != 3'b000) begin
         got = {bus.bankWrEn, bus.bankWrAddr, bus.bankWrData};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got en=%b addr=%0d data=%h, expected no write",
                     got.en, got.addr, got.data);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               failures++;
               $display("FAIL bank_write: got en=%b addr=%0d data=%h, expected en=%b addr=%0d data=%h",
                        got.en, got.addr, got.data, want.en, want.addr, want.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pxlClk);
      #1;
   endtask

   task automatic push_fill(input int bank, input int line, input int npx);
      wr_t w;
      for (int p = 0; p < npx; p++) begin
         w.en   = 3'(1 << bank);
         w.addr = 8'(p);
         w.data = pix(8'(line), 8'(p));
         exp_q.push_back(w);
      end
   endtask

   task automatic rotate();
      nextLine = 1'b1;
      cacheUpdate = 1'b1;
      tick();
      nextLine = 1'b0;
      cacheUpdate = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      bus.srcGrant = 1'b0;
      repeat (3) tick();
      chk("rst_lineIdx", lineIdx, 0);
      chk("rst_prevSel", prevSel, 1);
      chk("rst_curSel", curSel, 1);
      chk("rst_nextSel", nextSel, 2);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_srcRdEn", bus.srcRdEn, 0);
      chk("rst_srcRdLine", bus.srcRdLine, 0);
      chk("rst_srcRdPxl", bus.srcRdPxl, 0);
      chk("rst_bankWrEn", bus.bankWrEn, 0);
      chk("rst_bankWrAddr", bus.bankWrAddr, 0);
      rst = 1'b0;
      mon_on = 1'b1;
      tick();

      // Priming: line 0 into bank 1, line 1 into bank 2.
      push_fill(1, 0, 240);
      push_fill(2, 1, 240);
      bus.srcGrant = 1'b1;
      newFrameIn = 1'b1;
      tick();
      wait_idle(n);
      chk("prime_cycles", n, 482);
      chk("prime_lineIdx", lineIdx, 0);
      chk("prime_prevSel", prevSel, 1);
      chk("prime_curSel", curSel, 1);
      chk("prime_nextSel", nextSel, 2);

      // Rotation from line 0: bank 0 refilled with line 2.
      push_fill(0, 2, 240);
      rotate();
      chk("rot1_lineIdx", lineIdx, 1);
      chk("rot1_prevSel", prevSel, 1);
      chk("rot1_curSel", curSel, 2);
      chk("rot1_nextSel", nextSel, 0);
      wait_idle(n);
      chk("rot1_fill_cycles", n, 241);

      // Grant alternating 1/0 starting with a granted cycle.
      push_fill(1, 3, 240);
      rotate();
      chk("grant_lineIdx", lineIdx, 2);
      n = 0;
      while (busy && n < 3000) begin
         bus.srcGrant = (n % 2 == 0);
         if (n == 1) begin
            #1;
            chk("ungranted_srcRdEn", bus.srcRdEn, 0);
            chk("ungranted_srcRdPxl", bus.srcRdPxl, 1);
         end
         tick();
         n++;
      end
      chk("grant_fill_cycles", n, 480);
      bus.srcGrant = 1'b1;

      // Two rotates during a fill: one queued, one dropped.
      newFrameIn = 1'b0;
      push_fill(2, 4, 240);
      rotate();
      chk("ovr_lineIdx", lineIdx, 3);
      repeat (10) tick();
      push_fill(0, 5, 240);
      rotate();
      chk("ovr_set", overrun, 1);
      repeat (10) tick();
      rotate();
      repeat (600) tick();
      chk("ovr_busy", busy, 0);
      chk("ovr_lineIdx_final", lineIdx, 4);
      chk("ovr_sticky", overrun, 1);
      chk("ovr_prevSel", prevSel, 1);
      chk("ovr_curSel", curSel, 2);
      chk("ovr_nextSel", nextSel, 0);

      // New frame at pixel 100 of a fill.
      push_fill(1, 6, 100);
      rotate();
      n = 0;
      while (bus.srcRdPxl != 8'd100 && n < 1000) begin
         tick();
         n++;
      end
      chk("abort_reach_px100", bus.srcRdPxl, 100);
      push_fill(1, 0, 240);
      push_fill(2, 1, 240);
      newFrameIn = 1'b1;
      tick();
      chk("abort_bankWrEn", bus.bankWrEn, 0);
      chk("abort_overrun", overrun, 0);
      chk("abort_lineIdx", lineIdx, 0);
      chk("abort_srcRdPxl", bus.srcRdPxl, 0);
      chk("abort_srcRdLine", bus.srcRdLine, 0);
      chk("abort_busy", busy, 1);
      wait_idle(n);
      chk("abort_prime_cycles", n, 482);

      // Walk down to the last line; role of bank at line L is p0 = L mod 3.
      for (int l = 0; l < 159; l++) begin
         if (l <= 157) push_fill(l % 3, l + 2, 240);
         rotate();
         wait_idle(n);
         chk($sformatf("walk_fill_cycles_%0d", l), n, (l <= 157) ? 241 : 0);
      end
      chk("last_lineIdx", lineIdx, 159);
      chk("last_prevSel", prevSel, 0);
      chk("last_curSel", curSel, 1);
      chk("last_nextSel", nextSel, 1);
      rotate();
      chk("last_rot_lineIdx", lineIdx, 159);
      chk("last_rot_busy", busy, 0);
      chk("last_rot_overrun", overrun, 0);
      chk("last_rot_curSel", curSel, 1);
      tick();
      chk("last_rot_busy2", busy, 0);

      repeat (5) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
